// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage: owns HI/LO and stalls dependent D-stage MDU ops.
// Optional `MDU_DIV0_GUARD_EN turns division by zero into a no-op instead of a full-length DIV.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic [3:0]  MDU_OP_E,
  input  logic [31:0] MDU_A_E,
  input  logic [31:0] MDU_B_E,
  input  logic        MDU_USE_D,
  output logic        MDU_BUSY,
  output logic [31:0] MDU_RD_E,
  output logic        MDU_STALL,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [4:0] MulCnt = 5'(MULT_CYCLES);
  localparam logic [4:0] DivCnt = 5'(DIV_CYCLES);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] phi_q, plo_q, hi_q, lo_q;
  logic        busy_q;

  logic        is_mul, is_div, is_start, start_eff, div_zero;
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] ua, ub, uq, ur, q, r;
  logic [31:0] res_hi, res_lo;

  assign is_mul   = (MDU_OP_E == 4'd1) || (MDU_OP_E == 4'd2);
  assign is_div   = (MDU_OP_E == 4'd3) || (MDU_OP_E == 4'd4);
  assign is_start = is_mul || is_div;
  assign div_zero = is_div && (MDU_B_E == 32'd0);

`ifdef MDU_DIV0_GUARD_EN
  assign start_eff = is_start && !div_zero;
`else
  assign start_eff = is_start;
`endif

  assign prod_s = $signed({{32{MDU_A_E[31]}}, MDU_A_E}) * $signed({{32{MDU_B_E[31]}}, MDU_B_E});
  assign prod_u = {32'd0, MDU_A_E} * {32'd0, MDU_B_E};

  // Signed division via magnitudes; this also makes 0x80000000 / -1 wrap to 0x80000000.
  assign a_neg = (MDU_OP_E == 4'd3) && MDU_A_E[31];
  assign b_neg = (MDU_OP_E == 4'd3) && MDU_B_E[31];
  assign ua    = a_neg ? (32'd0 - MDU_A_E) : MDU_A_E;
  assign ub    = (MDU_B_E == 32'd0) ? 32'd1 : (b_neg ? (32'd0 - MDU_B_E) : MDU_B_E);
  assign uq    = ua / ub;
  assign ur    = ua % ub;
  assign q     = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign r     = a_neg ? (32'd0 - ur) : ur;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    if (MDU_OP_E == 4'd1) begin
      res_hi = prod_s[63:32];
      res_lo = prod_s[31:0];
    end else if (MDU_OP_E == 4'd2) begin
      res_hi = prod_u[63:32];
      res_lo = prod_u[31:0];
    end else if (div_zero) begin
      res_hi = MDU_A_E;
      res_lo = 32'hFFFF_FFFF;
    end else if (is_div) begin
      res_hi = r;
      res_lo = q;
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_eff) begin
            phi_q   <= res_hi;
            plo_q   <= res_lo;
            cnt_q   <= is_mul ? MulCnt : DivCnt;
            state_q <= StBusy;
            busy_q  <= 1'b1;
          end else if (MDU_OP_E == 4'd5) begin
            hi_q <= MDU_A_E;
          end else if (MDU_OP_E == 4'd6) begin
            lo_q <= MDU_A_E;
          end
        end
        StBusy: begin
          // New ops arriving while busy are dropped; the stall controller must hold them in D.
          if (cnt_q == 5'd1) begin
            hi_q    <= phi_q;
            lo_q    <= plo_q;
            cnt_q   <= 5'd0;
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    MDU_RD_E = 32'd0;
    case (MDU_OP_E)
      4'd7:    MDU_RD_E = hi_q;
      4'd8:    MDU_RD_E = lo_q;
      default: MDU_RD_E = 32'd0;
    endcase
  end

  assign MDU_STALL = MDU_USE_D && (busy_q || is_start);
  assign MDU_BUSY  = busy_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table of mult/div ops with a HI/LO scoreboard,
// plus hand sequences for MTLO/MFLO, divide by zero and mid-operation reset.
module tb_mdu_ctrl;

  logic        clk;
  logic        RESET_N;
  logic [3:0]  MDU_OP_E;
  logic [31:0] MDU_A_E, MDU_B_E;
  logic        MDU_USE_D;
  logic        MDU_BUSY, MDU_STALL;
  logic [31:0] MDU_RD_E, HI, LO;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        use_d;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  vec_t        vecs[8];
  res_t        sb[$];
  logic [31:0] cur_hi, cur_lo;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .RESET_N   (RESET_N),
    .MDU_OP_E  (MDU_OP_E),
    .MDU_A_E   (MDU_A_E),
    .MDU_B_E   (MDU_B_E),
    .MDU_USE_D (MDU_USE_D),
    .MDU_BUSY  (MDU_BUSY),
    .MDU_RD_E  (MDU_RD_E),
    .MDU_STALL (MDU_STALL),
    .HI        (HI),
    .LO        (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Caller is at a negedge; returns at the negedge of the first idle cycle after the op.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input int exp_busy,
                        input logic [31:0] ehi, input logic [31:0] elo);
    res_t e;
    int   n;
    bit   done;
    MDU_OP_E  = op;
    MDU_A_E   = a;
    MDU_B_E   = b;
    MDU_USE_D = use_d;
    sb.push_back('{hi: ehi, lo: elo});
    #1 chk("stall_start", 32'(MDU_STALL), 32'(use_d));
    @(posedge clk);
    #1 MDU_OP_E = 4'd0;
    n = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (MDU_BUSY) begin
        n++;
        chk("stall_busy", 32'(MDU_STALL), 32'(use_d));
      end else begin
        done = 1;
      end
    end
    chk("busy_cycles", n, exp_busy);
    chk("stall_after", 32'(MDU_STALL), 32'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("hi", HI, e.hi);
      chk("lo", LO, e.lo);
    end else begin
      chk("scoreboard_empty", 32'(sb.size()), 32'd1);
    end
    cur_hi    = ehi;
    cur_lo    = elo;
    MDU_USE_D = 1'b0;
  endtask

  initial begin
    vecs[0] = '{op: 4'd1, a: 32'hFFFF_FFFD, b: 32'd5,         use_d: 1'b0,
                hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFF1};
    vecs[1] = '{op: 4'd2, a: 32'hFFFF_FFFF, b: 32'd2,         use_d: 1'b1,
                hi: 32'h0000_0001, lo: 32'hFFFF_FFFE};
    vecs[2] = '{op: 4'd4, a: 32'd7,         b: 32'd2,         use_d: 1'b0,
                hi: 32'd1,         lo: 32'd3};
    vecs[3] = '{op: 4'd3, a: 32'hFFFF_FFF9, b: 32'd2,         use_d: 1'b1,
                hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD};
    vecs[4] = '{op: 4'd3, a: 32'h8000_0000, b: 32'hFFFF_FFFF, use_d: 1'b0,
                hi: 32'd0,         lo: 32'h8000_0000};
    vecs[5] = '{op: 4'd1, a: 32'h8000_0000, b: 32'h8000_0000, use_d: 1'b0,
                hi: 32'h4000_0000, lo: 32'd0};
    vecs[6] = '{op: 4'd3, a: 32'd7,         b: 32'hFFFF_FFFE, use_d: 1'b1,
                hi: 32'd1,         lo: 32'hFFFF_FFFD};
    vecs[7] = '{op: 4'd2, a: 32'h1234_5678, b: 32'h10,        use_d: 1'b0,
                hi: 32'd1,         lo: 32'h2345_6780};

    RESET_N   = 1'b0;
    MDU_OP_E  = 4'd0;
    MDU_A_E   = 32'd0;
    MDU_B_E   = 32'd0;
    MDU_USE_D = 1'b0;
    #12 RESET_N = 1'b1;

    @(negedge clk);
    chk("rst_busy", 32'(MDU_BUSY), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    MDU_OP_E = 4'd7;
    #1 chk("rst_rd", MDU_RD_E, 32'd0);
    MDU_OP_E = 4'd0;

    // Each op is issued in the first idle cycle of the previous one: back-to-back.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].use_d,
             (vecs[i].op <= 4'd2) ? 5 : 10, vecs[i].hi, vecs[i].lo);
    end

    // MTLO then MFLO in the very next E cycle.
    MDU_OP_E = 4'd6;
    MDU_A_E  = 32'h0000_1234;
    @(negedge clk);
    MDU_OP_E = 4'd8;
    MDU_A_E  = 32'd0;
    #1 chk("mflo_rd", MDU_RD_E, 32'h0000_1234);
    MDU_OP_E = 4'd7;
    #1 chk("mfhi_rd", MDU_RD_E, cur_hi);
    chk("mtlo_nobusy", 32'(MDU_BUSY), 32'd0);
    MDU_OP_E = 4'd0;
    cur_lo   = 32'h0000_1234;
    @(negedge clk);

`ifdef MDU_DIV0_GUARD_EN
    run_op(4'd3, 32'h55, 32'd0, 1'b1, 0, cur_hi, cur_lo);
`else
    run_op(4'd3, 32'h55, 32'd0, 1'b1, 10, 32'h0000_0055, 32'hFFFF_FFFF);
`endif

    // Reset asserted in busy cycle 3 of a DIV discards the result at once.
    MDU_OP_E = 4'd3;
    MDU_A_E  = 32'd100;
    MDU_B_E  = 32'd7;
    @(posedge clk);
    #1 MDU_OP_E = 4'd0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(MDU_BUSY), 32'd1);
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(MDU_BUSY), 32'd0);
    chk("mid_rst_hi", HI, 32'd0);
    chk("mid_rst_lo", LO, 32'd0);
    #1 RESET_N = 1'b1;
    @(negedge clk);
    MDU_OP_E = 4'd5;
    MDU_A_E  = 32'hA5A5_A5A5;
    @(negedge clk);
    MDU_OP_E = 4'd0;
    #1;
    chk("mthi_hi", HI, 32'hA5A5_A5A5);
    chk("mthi_lo", LO, 32'd0);
    chk("mthi_busy", 32'(MDU_BUSY), 32'd0);
    repeat (12) @(negedge clk);
    chk("post_rst_hi", HI, 32'hA5A5_A5A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
